// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared requester index, read-tag and one-hot helper for the dpram arbiter
package dpram_arb_pkg;
  localparam int MAX_REQ = 16;
  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rd_tag_t;
  function automatic logic [MAX_REQ-1:0] onehot(input req_idx_t idx);
    return MAX_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/dpram_rr_pick.sv
// dpram_rr_pick: combinational round-robin picker, first eligible at or after ptr with wrap
module dpram_rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] elig,
  input  req_idx_t           ptr,
  output logic               found,
  output req_idx_t           win
);
  logic [NUM_REQ-1:0] rot;
  int s;
  assign rot = NUM_REQ'({elig, elig} >> ptr);
  // descending scan so the lowest rotated offset is the last assignment
  always_comb begin
    found = 1'b0;
    s = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        s = int'(ptr) + k;
      end
    win = req_idx_t'(s >= NUM_REQ ? s - NUM_REQ : s);
  end
endmodule

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: round-robin sharing of one sync read-first dpram port with tagged read return.
// Define DPRAM_ARB_COLLIDE_EN to stall writes that collide with the other port's write.
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [MEM_WIDTH-1:0]          rdata,
  output logic                          mem_csn,
  output logic                          mem_wen,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [MEM_WIDTH-1:0]          mem_wdata,
`ifdef DPRAM_ARB_COLLIDE_EN
  input  logic                          pb_csn,
  input  logic                          pb_wen,
  input  logic [ADDR_WIDTH-1:0]         pb_addr,
  output logic                          collide_stall,
`endif
  input  logic [MEM_WIDTH-1:0]          mem_rdata
);
  logic [NUM_REQ-1:0]    elig, w_oh;
  logic                  found, we_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [MEM_WIDTH-1:0]  wdata_w;
  req_idx_t              w, ptr;
  rd_tag_t               t1, t2;
`ifdef DPRAM_ARB_COLLIDE_EN
  logic [NUM_REQ-1:0] blk;
  always_comb begin
    blk = '0;
    for (int i = 0; i < NUM_REQ; i++)
      blk[i] = we[i] && !pb_csn && !pb_wen && addr[i*ADDR_WIDTH +: ADDR_WIDTH] == pb_addr;
  end
  assign elig = req & ~blk;
`else
  assign elig = req;
`endif
  dpram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.elig(elig), .ptr(ptr), .found(found), .win(w));
  assign w_oh = NUM_REQ'(onehot(w));
  always_comb begin
    we_w = 1'b0;
    addr_w = '0;
    wdata_w = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_oh[i]) begin
        we_w = we[i];
        addr_w = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_w = wdata[i*MEM_WIDTH +: MEM_WIDTH];
      end
  end
  assign rvalid = t2.valid ? NUM_REQ'(onehot(t2.idx)) : '0;
  assign rdata = mem_rdata;
  // t1 covers the command cycle, t2 the cycle the memory presents read data
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      mem_csn <= 1'b1;
      mem_wen <= 1'b1;
      mem_addr <= '0;
      mem_wdata <= '0;
      ptr <= '0;
      t1 <= '0;
      t2 <= '0;
`ifdef DPRAM_ARB_COLLIDE_EN
      collide_stall <= 1'b0;
`endif
    end else begin
      gnt <= found ? w_oh : '0;
      mem_csn <= !found;
      mem_wen <= !(found && we_w);
      if (found) begin
        mem_addr <= addr_w;
        mem_wdata <= wdata_w;
        ptr <= (w == req_idx_t'(NUM_REQ - 1)) ? '0 : w + req_idx_t'(1);
      end
      t1 <= '{valid: found && !we_w, idx: w};
      t2 <= t1;
`ifdef DPRAM_ARB_COLLIDE_EN
      collide_stall <= |(req & blk);
`endif
    end
  end
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb_dpram_rr_arbiter: randomized and directed checks against a transaction-level reference model
module tb_dpram_rr_arbiter;
  localparam int N = 4, AW = 4, DW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, we = '0, gnt, rvalid;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic mem_csn, mem_wen;
`ifdef DPRAM_ARB_COLLIDE_EN
  logic pb_csn = 1'b1, pb_wen = 1'b1, collide_stall;
  logic [AW-1:0] pb_addr = '0;
`endif
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  int n_pass = 0, n_chk = 0;
  int m_ptr = 0;
  logic [N-1:0] e_gnt;
  logic e_csn, e_wen, e_stall;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic pv [2];
  int pi [2];
  logic [DW-1:0] pd [2];

  dpram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .MEM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_csn(mem_csn), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DPRAM_ARB_COLLIDE_EN
    .pb_csn(pb_csn), .pb_wen(pb_wen), .pb_addr(pb_addr), .collide_stall(collide_stall),
`endif
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!mem_csn) begin
      if (!mem_wen) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic blocked(input int i);
`ifdef DPRAM_ARB_COLLIDE_EN
    return we[i] && !pb_csn && !pb_wen && addr[i*AW +: AW] == pb_addr;
`else
    return 1'b0;
`endif
  endfunction

  // model one edge at transaction level, then compare DUT outputs after it
  task automatic step();
    int w;
    logic [AW-1:0] a;
    w = -1;
    e_stall = 1'b0;
    if (rst) begin
      e_gnt = '0; e_csn = 1'b1; e_wen = 1'b1; e_addr = '0; e_wdata = '0;
      m_ptr = 0; pv[0] = 1'b0; pv[1] = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j] && blocked(j)) e_stall = 1'b1;
        if (w < 0 && req[j] && !blocked(j)) w = j;
      end
      pv[1] = pv[0]; pi[1] = pi[0]; pd[1] = pd[0];
      pv[0] = 1'b0;
      if (w >= 0) begin
        a = addr[w*AW +: AW];
        e_gnt = N'(1) << w; e_csn = 1'b0; e_wen = ~we[w];
        e_addr = a; e_wdata = wdata[w*DW +: DW];
        m_ptr = (w + 1) % N;
        if (we[w]) ref_mem[a] = wdata[w*DW +: DW];
        else begin pv[0] = 1'b1; pi[0] = w; pd[0] = ref_mem[a]; end
      end else begin
        e_gnt = '0; e_csn = 1'b1; e_wen = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("gnt", gnt, e_gnt);
    check("mem_csn", mem_csn, e_csn);
    check("mem_wen", mem_wen, e_wen);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("rvalid", rvalid, pv[1] ? N'(1) << pi[1] : '0);
    if (pv[1]) check("rdata", rdata, pd[1]);
`ifdef DPRAM_ARB_COLLIDE_EN
    check("collide_stall", collide_stall, e_stall);
`endif
  endtask

  task automatic set_req(input int i, input logic r, input logic w_, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w_; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'(i * 37);
      ref_mem[i] = DW'(i * 37);
    end
    pv[0] = 1'b0; pv[1] = 1'b0; pi[0] = 0; pi[1] = 0; pd[0] = '0; pd[1] = '0;
    // reset with all requests held
    req = '1;
    step(); step();
    check("reset_rvalid", rvalid, '0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_seq", gnt, N'(1) << (k % N));
    end
    // write then read the same address from another requester
    req = '0;
    step(); step();
    set_req(0, 1'b1, 1'b1, 4'd5, 8'hA5);
    step();
    check("wr_gnt", gnt, 4'b0001);
    req = '0;
    set_req(2, 1'b1, 1'b0, 4'd5, 8'h00);
    step();
    check("wr_no_rvalid", rvalid, 4'b0000);
    check("rd_gnt", gnt, 4'b0100);
    req = '0;
    step();
    check("rd_rvalid", rvalid, 4'b0100);
    check("rd_data", rdata, 8'hA5);
    // ptr now 3 after the read; grant 0 to put ptr at 1, then skip idle to 3
    set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
    step();
    req = '0;
    set_req(3, 1'b1, 1'b0, 4'd2, 8'h00);
    step();
    check("skip_gnt", gnt, 4'b1000);
    req = '0;
    step();
    check("idle_csn", mem_csn, 1'b1);
    req = 4'b0011;
    step();
    check("wrap_gnt", gnt, 4'b0001);
    // reset right after a read grant
    req = '0;
    step(); step();
    set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
    step();
    req = '0;
    rst = 1'b1;
    step();
    check("rst_mid_rvalid", rvalid, '0);
    check("rst_mid_addr", mem_addr, '0);
    rst = 1'b0;
    step();
    check("post_rst_rvalid", rvalid, '0);
`ifdef DPRAM_ARB_COLLIDE_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    pb_csn = 1'b0; pb_wen = 1'b0; pb_addr = 4'd3;
    set_req(1, 1'b1, 1'b1, 4'd3, 8'h3C);
    set_req(2, 1'b1, 1'b0, 4'd9, 8'h00);
    step();
    check("col_gnt_first", gnt, 4'b0100);
    check("col_stall", collide_stall, 1'b1);
    pb_csn = 1'b1;
    req[2] = 1'b0;
    step();
    check("col_gnt_after", gnt, 4'b0010);
    req = '0;
`endif
    // randomized traffic honoring the hold-until-granted handshake
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] || e_gnt[i])
          set_req(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)), DW'($urandom));
`ifdef DPRAM_ARB_COLLIDE_EN
      pb_csn = 1'($urandom_range(0, 1)); pb_wen = 1'($urandom_range(0, 1));
      pb_addr = AW'($urandom_range(0, 3));
`endif
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
